fwd_unit_param: RTL and testbench

Parametrised operand-forwarding and interlock controller for the pipelined MIPS core, sitting between the ID stage register-file read and the ID/EX pipeline register. It compares NSRC ID source register numbers against NSTG in-flight producer stages and selects the youngest match. It detects load-use hazards and either bypasses combinationally or, when REG_FWD=1, captures forwarded data into hold registers at the cost of one stall cycle. Two saturating counters record forwarding stalls and load-use stalls for performance analysis.

---
 rtl/fwd_unit_param.sv | 127 ++++++++++++
 tb/tb_fwd_unit_param.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_unit_param.sv
// Operand forwarding and load-use interlock between the ID register-file read and ID/EX.
// REG_FWD=1 registers bypassed data into hold registers for one stall cycle; REG_FWD=0 bypasses directly.
module fwd_unit_param #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int NSTG    = 3,
    parameter int REG_FWD = 1,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSTG-1:0]      stg_we,
    input  logic [NSTG*AW-1:0]   stg_rw,
    input  logic [NSTG*XLEN-1:0] stg_data,
    input  logic [NSTG-1:0]      stg_ld,
    input  logic                 stall_ext,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC*XLEN-1:0] id_rf_data,
    input  logic                 cnt_clr,
    output logic [NSRC*XLEN-1:0] op_data,
    output logic [NSRC-1:0]      op_fwd,
    output logic                 stall_id,
    output logic [CNTW-1:0]      cnt_fwd,
    output logic [CNTW-1:0]      cnt_ld
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t                state_p1;
    logic [NSRC*XLEN-1:0]  hold_p1;
    logic [NSRC-1:0]       hflag_p1;

    logic [NSRC-1:0]       hit_p0;
    logic [NSRC-1:0]       hit_ld_p0;
    logic [NSRC*XLEN-1:0]  sel_data_p0;
    logic                  ld_haz;
    logic                  any_hit;
    logic                  capture;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: scan oldest to youngest so the youngest matching producer is the last one written.
    always_comb begin
        hit_p0      = '0;
        hit_ld_p0   = '0;
        sel_data_p0 = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (id_valid && stg_we[s] && (stg_rw[s*AW +: AW] != '0) &&
                    (stg_rw[s*AW +: AW] == id_rs[j*AW +: AW])) begin
                    hit_p0[j]                     = 1'b1;
                    hit_ld_p0[j]                  = stg_ld[s];
                    sel_data_p0[j*XLEN +: XLEN]   = stg_data[s*XLEN +: XLEN];
                end
            end
        end
    end

    assign ld_haz  = |hit_ld_p0;
    assign any_hit = |hit_p0;
    assign capture = (REG_FWD != 0) && (state_p1 == IDLE) && !ld_haz && any_hit && !stall_ext;

    always_comb begin
        op_data  = id_rf_data;
        op_fwd   = '0;
        stall_id = 1'b0;
        if (REG_FWD == 0) begin
            for (int j = 0; j < NSRC; j++) begin
                if (hit_p0[j])
                    op_data[j*XLEN +: XLEN] = sel_data_p0[j*XLEN +: XLEN];
            end
            op_fwd   = hit_p0 & {NSRC{~ld_haz}};
            stall_id = ld_haz;
        end else if (state_p1 == HOLD) begin
            for (int j = 0; j < NSRC; j++) begin
                if (hflag_p1[j])
                    op_data[j*XLEN +: XLEN] = hold_p1[j*XLEN +: XLEN];
            end
            op_fwd = hflag_p1;
        end else begin
            stall_id = ld_haz | any_hit;
        end
        if (!rst_n) begin
            stall_id = 1'b0;
            op_fwd   = '0;
        end
    end

    // Stage p1: hold registers; matches are not re-evaluated while HOLD presents them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            hold_p1  <= '0;
            hflag_p1 <= '0;
        end else begin
            case (state_p1)
                IDLE: if (capture) begin
                    hold_p1  <= sel_data_p0;
                    hflag_p1 <= hit_p0;
                    state_p1 <= HOLD;
                end
                HOLD: if (!stall_ext) begin
                    hflag_p1 <= '0;
                    state_p1 <= IDLE;
                end
                default: state_p1 <= IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an increment wins.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_fwd <= '0;
            cnt_ld  <= '0;
        end else if (stall_id && !stall_ext) begin
            if (ld_haz)
                cnt_ld <= sat_inc(cnt_ld);
            else
                cnt_fwd <= sat_inc(cnt_fwd);
        end
    end

endmodule

// File: tb/tb_fwd_unit_param.sv
// Scoreboard bench for fwd_unit_param: registered (16- and 2-bit counters) and combinational variants.
module tb_fwd_unit_param;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int NSTG = 3;
    localparam logic [31:0] RF0 = 32'h1000_0000;
    localparam logic [31:0] RF1 = 32'h2000_0000;
    localparam logic [63:0] RF  = {RF1, RF0};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NSTG-1:0]      stg_we, stg_ld;
    logic [NSTG*AW-1:0]   stg_rw;
    logic [NSTG*XLEN-1:0] stg_data;
    logic                 stall_ext, id_valid, cnt_clr;
    logic [NSRC*AW-1:0]   id_rs;
    logic [NSRC*XLEN-1:0] id_rf_data;

    logic [NSRC*XLEN-1:0] op_data1, op_data0, op_data2;
    logic [NSRC-1:0]      op_fwd1, op_fwd0, op_fwd2;
    logic                 stall1, stall0, stall2;
    logic [15:0]          cnt_fwd1, cnt_ld1, cnt_fwd0, cnt_ld0;
    logic [1:0]           cnt_fwd2, cnt_ld2;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       nm;
        logic [63:0] od;
        logic [1:0]  fwd;
        logic        st;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    fwd_unit_param #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .REG_FWD(1), .CNTW(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .stg_we(stg_we), .stg_rw(stg_rw), .stg_data(stg_data),
        .stg_ld(stg_ld), .stall_ext(stall_ext), .id_valid(id_valid), .id_rs(id_rs),
        .id_rf_data(id_rf_data), .cnt_clr(cnt_clr), .op_data(op_data1), .op_fwd(op_fwd1),
        .stall_id(stall1), .cnt_fwd(cnt_fwd1), .cnt_ld(cnt_ld1));

    fwd_unit_param #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .REG_FWD(0), .CNTW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .stg_we(stg_we), .stg_rw(stg_rw), .stg_data(stg_data),
        .stg_ld(stg_ld), .stall_ext(stall_ext), .id_valid(id_valid), .id_rs(id_rs),
        .id_rf_data(id_rf_data), .cnt_clr(cnt_clr), .op_data(op_data0), .op_fwd(op_fwd0),
        .stall_id(stall0), .cnt_fwd(cnt_fwd0), .cnt_ld(cnt_ld0));

    fwd_unit_param #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .REG_FWD(1), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stg_we(stg_we), .stg_rw(stg_rw), .stg_data(stg_data),
        .stg_ld(stg_ld), .stall_ext(stall_ext), .id_valid(id_valid), .id_rs(id_rs),
        .id_rf_data(id_rf_data), .cnt_clr(cnt_clr), .op_data(op_data2), .op_fwd(op_fwd2),
        .stall_id(stall2), .cnt_fwd(cnt_fwd2), .cnt_ld(cnt_ld2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stg(input int s, input logic we, input logic [4:0] rw,
                           input logic [31:0] d, input logic ld);
        stg_we[s]            = we;
        stg_rw[s*AW +: AW]   = rw;
        stg_data[s*XLEN +: XLEN] = d;
        stg_ld[s]            = ld;
    endtask

    task automatic clr_stg();
        stg_we   = '0;
        stg_ld   = '0;
        stg_rw   = '0;
        stg_data = '0;
    endtask

    task automatic set_rs(input logic [4:0] r1, input logic [4:0] r0);
        id_rs = {r1, r0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        set_rs(5'd9, 5'd8);
        set_stg(1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
        exp_q.push_back(exp_t'{"reset_idle", RF, 2'b00, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({stall0, op_fwd0} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_comb_gate: got stall=%b fwd=%b want 0/00", stall0, op_fwd0);
        end
        compared++;
        if ({cnt_fwd1, cnt_ld1} !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_fwd1, cnt_ld1);
        end
        clr_stg();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fwd_basic();
        set_rs(5'd9, 5'd8);
        set_stg(1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
        exp_q.push_back(exp_t'{"basic_idle", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        step();
        set_stg(1, 1'b1, 5'd8, 32'h1234_5678, 1'b0);
        exp_q.push_back(exp_t'{"basic_hold", {RF1, 32'hDEAD_BEEF}, 2'b01, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if (cnt_fwd1 !== 16'd1) begin
            mismatched++;
            $display("FAIL basic_cnt_fwd: got %0d want 1", cnt_fwd1);
        end
        step();
        clr_stg();
        exp_q.push_back(exp_t'{"basic_back_idle", RF, 2'b00, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        step();
    endtask

    task automatic test_youngest();
        set_rs(5'd9, 5'd8);
        set_stg(0, 1'b1, 5'd8, 32'h0000_0011, 1'b0);
        set_stg(2, 1'b1, 5'd8, 32'h0000_0022, 1'b0);
        exp_q.push_back(exp_t'{"young_idle", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({op_data0, op_fwd0, stall0} !== {RF1, 32'h0000_0011, 2'b01, 1'b0}) begin
            mismatched++;
            $display("FAIL young_comb: got %h/%b/%b want %h/01/0", op_data0, op_fwd0, stall0, {RF1, 32'h11});
        end
        step();
        clr_stg();
        exp_q.push_back(exp_t'{"young_hold", {RF1, 32'h0000_0011}, 2'b01, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if (cnt_fwd1 !== 16'd2) begin
            mismatched++;
            $display("FAIL young_cnt_fwd: got %0d want 2", cnt_fwd1);
        end
        step();
    endtask

    task automatic test_load_use();
        set_rs(5'd9, 5'd8);
        set_stg(0, 1'b1, 5'd9, 32'h0000_0BAD, 1'b1);
        set_stg(1, 1'b1, 5'd9, 32'h0000_0077, 1'b0);
        exp_q.push_back(exp_t'{"ld_stall", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({op_data0, op_fwd0, stall0} !== {32'h0000_0BAD, RF0, 2'b00, 1'b1}) begin
            mismatched++;
            $display("FAIL ld_comb: got %h/%b/%b want %h/00/1", op_data0, op_fwd0, stall0, {32'hBAD, RF0});
        end
        step();
        set_stg(0, 1'b1, 5'd9, 32'h0000_0099, 1'b0);
        exp_q.push_back(exp_t'{"ld_capture", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({cnt_ld1, cnt_fwd1, cnt_ld0} !== {16'd1, 16'd2, 16'd1}) begin
            mismatched++;
            $display("FAIL ld_cnt: got ld=%0d fwd=%0d ld0=%0d want 1/2/1", cnt_ld1, cnt_fwd1, cnt_ld0);
        end
        step();
        clr_stg();
        exp_q.push_back(exp_t'{"ld_hold", {32'h0000_0099, RF0}, 2'b10, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({cnt_ld1, cnt_fwd1} !== {16'd1, 16'd3}) begin
            mismatched++;
            $display("FAIL ld_hold_cnt: got ld=%0d fwd=%0d want 1/3", cnt_ld1, cnt_fwd1);
        end
        step();
    endtask

    task automatic test_stall_ext_hold();
        set_rs(5'd9, 5'd8);
        set_stg(1, 1'b1, 5'd8, 32'hCAFE_0001, 1'b0);
        exp_q.push_back(exp_t'{"sx_idle", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        step();
        stall_ext = 1'b1;
        set_stg(1, 1'b1, 5'd8, 32'hFFFF_FFFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(exp_t'{"sx_hold_frozen", {RF1, 32'hCAFE_0001}, 2'b01, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if ({op_data1, op_fwd1, stall1, cnt_fwd1, cnt_ld1} !== {e.od, e.fwd, e.st, 16'd4, 16'd1}) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h/%b/%b cnt %0d/%0d want %h/%b/%b cnt 4/1", e.nm, k,
                         op_data1, op_fwd1, stall1, cnt_fwd1, cnt_ld1, e.od, e.fwd, e.st);
            end
            step();
        end
        stall_ext = 1'b0;
        clr_stg();
        exp_q.push_back(exp_t'{"sx_hold_release", {RF1, 32'hCAFE_0001}, 2'b01, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        step();
        exp_q.push_back(exp_t'{"sx_back_idle", RF, 2'b00, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        // Frozen pipeline in IDLE: stall asserted but no capture and no count.
        set_stg(1, 1'b1, 5'd8, 32'hCAFE_0002, 1'b0);
        stall_ext = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exp_t'{"sx_idle_frozen", RF, 2'b00, 1'b1});
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if ({op_data1, op_fwd1, stall1, cnt_fwd1} !== {e.od, e.fwd, e.st, 16'd4}) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h/%b/%b cnt %0d want %h/%b/%b cnt 4", e.nm, k,
                         op_data1, op_fwd1, stall1, cnt_fwd1, e.od, e.fwd, e.st);
            end
            step();
        end
        clr_stg();
        stall_ext = 1'b0;
        step();
    endtask

    task automatic test_r0();
        set_rs(5'd0, 5'd0);
        set_stg(0, 1'b1, 5'd0, 32'h0000_0ABC, 1'b0);
        set_stg(2, 1'b1, 5'd0, 32'h0000_0DEF, 1'b1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exp_t'{"r0_nomatch", RF, 2'b00, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h/%b/%b want %h/%b/%b", e.nm, k, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
            end
            compared++;
            if ({op_data0, op_fwd0, stall0} !== {RF, 2'b00, 1'b0}) begin
                mismatched++;
                $display("FAIL r0_comb[%0d]: got %h/%b/%b want %h/00/0", k, op_data0, op_fwd0, stall0, RF);
            end
            step();
        end
        clr_stg();
    endtask

    task automatic test_comb_bypass();
        set_rs(5'd5, 5'd3);
        set_stg(2, 1'b1, 5'd5, 32'h0000_0055, 1'b0);
        exp_q.push_back(exp_t'{"bypass_reg_idle", RF, 2'b00, 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        compared++;
        if ({op_data0, op_fwd0, stall0} !== {32'h0000_0055, RF0, 2'b10, 1'b0}) begin
            mismatched++;
            $display("FAIL bypass_comb: got %h/%b/%b want %h/10/0", op_data0, op_fwd0, stall0, {32'h55, RF0});
        end
        step();
        clr_stg();
        step();
        step();
    endtask

    task automatic test_back_to_back_sat();
        set_rs(5'd9, 5'd8);
        set_stg(1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        compared++;
        if ({cnt_fwd1, cnt_fwd2} !== 18'd0) begin
            mismatched++;
            $display("FAIL clr_drops_inc: got %0d/%0d want 0/0", cnt_fwd1, cnt_fwd2);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_t'{"b2b_idle", RF, 2'b00, 1'b1});
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if ({op_data1, op_fwd1, stall1, stall2} !== {e.od, e.fwd, e.st, e.st}) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h/%b/%b/%b want %h/%b/%b", e.nm, i, op_data1, op_fwd1, stall1, stall2, e.od, e.fwd, e.st);
            end
            step();
            exp_q.push_back(exp_t'{"b2b_hold", {RF1, 32'hDEAD_BEEF}, 2'b01, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if ({op_data1, op_fwd1, stall1, op_data2, op_fwd2} !== {e.od, e.fwd, e.st, e.od, e.fwd}) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h/%b/%b dut2 %h/%b want %h/%b/%b", e.nm, i, op_data1, op_fwd1, stall1,
                         op_data2, op_fwd2, e.od, e.fwd, e.st);
            end
            compared++;
            if ({cnt_fwd1, cnt_fwd2} !== {16'(i + 1), (i < 2) ? 2'(i + 1) : 2'd3}) begin
                mismatched++;
                $display("FAIL sat_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt_fwd1, cnt_fwd2, i + 1, (i < 2) ? i + 1 : 3);
            end
            step();
        end
        clr_stg();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        compared++;
        if ({cnt_fwd1, cnt_ld1, cnt_fwd2, cnt_ld2, cnt_fwd0} !== 52'd0) begin
            mismatched++;
            $display("FAIL cnt_clr: got %0d/%0d/%0d/%0d/%0d want all 0", cnt_fwd1, cnt_ld1, cnt_fwd2, cnt_ld2, cnt_fwd0);
        end
        step();
    endtask

    task automatic test_reset_mid_hold();
        set_rs(5'd9, 5'd8);
        set_stg(1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
        step();
        rst_n = 1'b0;
        exp_q.push_back(exp_t'{"rst_in_hold", {RF1, 32'hDEAD_BEEF}, 2'b00, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1} !== {e.od, e.fwd, e.st}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b want %h/%b/%b", e.nm, op_data1, op_fwd1, stall1, e.od, e.fwd, e.st);
        end
        step();
        clr_stg();
        rst_n = 1'b1;
        exp_q.push_back(exp_t'{"rst_abort_idle", RF, 2'b00, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if ({op_data1, op_fwd1, stall1, cnt_fwd1} !== {e.od, e.fwd, e.st, 16'd0}) begin
            mismatched++;
            $display("FAIL %s: got %h/%b/%b cnt %0d want %h/%b/%b cnt 0", e.nm, op_data1, op_fwd1, stall1, cnt_fwd1,
                     e.od, e.fwd, e.st);
        end
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        stall_ext  = 1'b0;
        id_valid   = 1'b1;
        cnt_clr    = 1'b0;
        id_rs      = '0;
        id_rf_data = RF;
        clr_stg();
        test_reset();
        test_fwd_basic();
        test_youngest();
        test_load_use();
        test_stall_ext_hold();
        test_r0();
        test_comb_bypass();
        test_back_to_back_sat();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
